// File: rtl/line_mem_ctrl_pkg.sv
// line_mem_ctrl_pkg: shared types for the cache memory-side path.
// Provides the cache<->memory request/response structs, the line/word
// geometry and the burst FSM state type used by line_mem_ctrl.
`timescale 1ns/1ps
package line_mem_ctrl_pkg;

  localparam int BEATS_PER_LINE = 4;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = BEATS_PER_LINE * WORD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    RESP = 2'd2
  } line_mem_state_t;

  // Line request from the cache controller; rw = 1 is a write-back.
  typedef struct packed {
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
    logic              rw;
    logic              valid;
  } mem_req_t;

  // Completion: data is the line, ready is a one-cycle pulse.
  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              ready;
  } mem_resp_t;

endpackage

// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: executes one 128-bit line request as a 4-beat 32-bit
// en/ack burst on an external word bus, then pulses mem_resp.ready.
// Ports: clk, rst (async, active-high); mem_req in / mem_resp out toward the
// cache; ext_en/ext_we/ext_addr/ext_wdata out, ext_rdata/ext_ack in toward
// the bus; mem_err out only when LINE_MEM_CTRL_TIMEOUT_EN is defined, which
// also enables the per-beat ack timeout of TIMEOUT cycles.
`timescale 1ns/1ps
module line_mem_ctrl
  import line_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_req_t    mem_req,
  output mem_resp_t   mem_resp,
  output logic        ext_en,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic [31:0] ext_rdata,
  input  logic        ext_ack
`ifdef LINE_MEM_CTRL_TIMEOUT_EN
  ,
  output logic        mem_err
`endif
);

  line_mem_state_t   state, state_nxt;
  logic [1:0]        beat;
  logic [1:0]        beat_inc;
  logic              rw_q;
  logic [27:0]       line_addr;
  logic [LINE_W-1:0] line_buf;
  logic              ready_q;

  // Byte offset bits of the request address are don't-care.
  logic unused_bits;
  assign unused_bits = ^{mem_req.addr[3:0], TIMEOUT[0]};

  assign beat_inc = beat + 2'd1;

`ifdef LINE_MEM_CTRL_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_hit;

  // wait_cnt counts un-acked cycles already spent on this beat, so hitting
  // TIMEOUT-1 with no ack now means TIMEOUT cycles have gone by.
  assign timeout_hit = (state == BEAT) && !ext_ack &&
                       (wait_cnt == WAIT_W'(TIMEOUT - 1));
`endif

  // The buffer doubles as the response register: it is only reloaded when
  // a new request is taken, so the returned line stays stable until then.
  assign mem_resp.data  = line_buf;
  assign mem_resp.ready = ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_req.valid) state_nxt = BEAT;
      BEAT: begin
        if (ext_ack && beat == 2'd3) state_nxt = RESP;
`ifdef LINE_MEM_CTRL_TIMEOUT_EN
        if (timeout_hit) state_nxt = RESP;
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are registered one step ahead: the address/data for the
  // next beat are loaded on the edge that retires the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat      <= 2'd0;
      rw_q      <= 1'b0;
      line_addr <= '0;
      line_buf  <= '0;
      ready_q   <= 1'b0;
      ext_en    <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
`ifdef LINE_MEM_CTRL_TIMEOUT_EN
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req.valid) begin
            rw_q      <= mem_req.rw;
            line_addr <= mem_req.addr[31:4];
            line_buf  <= mem_req.data;
            beat      <= 2'd0;
            ext_en    <= 1'b1;
            ext_we    <= mem_req.rw;
            ext_addr  <= {mem_req.addr[31:4], 4'h0};
            ext_wdata <= mem_req.data[WORD_W-1:0];
`ifdef LINE_MEM_CTRL_TIMEOUT_EN
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
`endif
          end
        end
        BEAT: begin
          if (ext_ack) begin
            if (!rw_q) line_buf[{beat, 5'd0} +: WORD_W] <= ext_rdata;
            if (beat == 2'd3) begin
              ext_en  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              beat      <= beat_inc;
              ext_addr  <= {line_addr, beat_inc, 2'b00};
              ext_wdata <= line_buf[{beat_inc, 5'd0} +: WORD_W];
            end
`ifdef LINE_MEM_CTRL_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            ext_en  <= 1'b0;
            ready_q <= 1'b1;
            mem_err <= 1'b1;
            // Words never delivered by the bus read back as zero.
            if (!rw_q) begin
              for (int i = 0; i < BEATS_PER_LINE; i++) begin
                if (2'(i) >= beat) line_buf[i*WORD_W +: WORD_W] <= '0;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
